// File: rtl/wb_stage_multilane.sv
// Multi-issue writeback stage: retires LANES instructions per cycle with in-bundle
// exception priority (oldest lane first), stall hold, post-exception kill window and retire counter.
module wb_stage_multilane #(
  parameter int LANES    = 2,
  parameter int DATA_W   = 32,
  parameter int RADDR_W  = 5,
  parameter int PC_W     = 32,
  parameter int KILL_CYC = 1,
  parameter int CNT_W    = 64,
  localparam int LPKT    = 1 + 1 + RADDR_W + DATA_W + PC_W + 1 + 6 + 9 + 1,
  localparam int RFW     = 1 + RADDR_W + DATA_W
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       wb_allowin,
  input  logic                       mem_to_wb_valid,
  input  logic [LANES*LPKT-1:0]      mem_to_wb_zip,
  input  logic                       wb_stall,
  output logic [LANES*RFW-1:0]       wb_rf_zip,
  output logic [LANES*PC_W-1:0]      debug_wb_pc,
  output logic [LANES*4-1:0]         debug_wb_rf_we,
  output logic [LANES*RADDR_W-1:0]   debug_wb_rf_wnum,
  output logic [LANES*DATA_W-1:0]    debug_wb_rf_wdata,
  output logic                       wb_ex_valid,
  output logic [PC_W-1:0]            wb_ex_pc,
  output logic [5:0]                 wb_ecode,
  output logic [8:0]                 wb_esubcode,
  output logic                       wb_is_ertn,
  output logic [CNT_W-1:0]           wb_retire_cnt
);

  localparam int O_ERTN  = 0;
  localparam int O_ESUB  = 1;
  localparam int O_ECODE = 10;
  localparam int O_EX    = 16;
  localparam int O_PC    = 17;
  localparam int O_WDATA = O_PC + PC_W;
  localparam int O_WADDR = O_WDATA + DATA_W;
  localparam int O_WE    = O_WADDR + RADDR_W;
  localparam int O_LV    = O_WE + 1;
  localparam int KCW     = (KILL_CYC > 1) ? $clog2(KILL_CYC) : 1;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_KILL = 1'b1;

  logic                    vld_p1;
  logic [LANES*LPKT-1:0]   zip_p1;
  logic [0:0]              state;
  logic [KCW-1:0]          kcnt;
  logic [CNT_W-1:0]        retire_cnt;

  logic [LANES-1:0]        lv, we, ex, ertn, before_k, commit, fwd;
  logic [RADDR_W-1:0]      waddr [LANES];
  logic [DATA_W-1:0]       wdata [LANES];
  logic [PC_W-1:0]         pc    [LANES];
  logic [5:0]              ecode [LANES];
  logic [8:0]              esub  [LANES];

  logic                    run, retire, k_found, k_ex, k_ertn;
  logic [PC_W-1:0]         k_pc;
  logic [5:0]              k_ecode;
  logic [8:0]              k_esub;
  logic [CNT_W-1:0]        inc;

  // stage p1: decode the held bundle
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lv[i]    = zip_p1[i*LPKT + O_LV];
      we[i]    = zip_p1[i*LPKT + O_WE];
      ex[i]    = zip_p1[i*LPKT + O_EX];
      ertn[i]  = zip_p1[i*LPKT + O_ERTN];
      waddr[i] = zip_p1[i*LPKT + O_WADDR +: RADDR_W];
      wdata[i] = zip_p1[i*LPKT + O_WDATA +: DATA_W];
      pc[i]    = zip_p1[i*LPKT + O_PC +: PC_W];
      ecode[i] = zip_p1[i*LPKT + O_ECODE +: 6];
      esub[i]  = zip_p1[i*LPKT + O_ESUB +: 9];
    end
  end

  // before_k[i] marks lanes strictly older than the first ex/ertn lane
  always_comb begin
    k_found  = 1'b0;
    k_ex     = 1'b0;
    k_ertn   = 1'b0;
    k_pc     = '0;
    k_ecode  = '0;
    k_esub   = '0;
    before_k = '0;
    for (int i = 0; i < LANES; i++) begin
      if (!k_found && lv[i] && (ex[i] || ertn[i])) begin
        k_found = 1'b1;
        k_ex    = ex[i];
        k_ertn  = ertn[i];
        k_pc    = pc[i];
        k_ecode = ecode[i];
        k_esub  = esub[i];
      end
      before_k[i] = ~k_found;
    end
  end

  assign run         = (state == ST_RUN);
  assign retire      = vld_p1 & ~wb_stall & run;
  assign wb_allowin  = ~vld_p1 | ~wb_stall | (state == ST_KILL);
  assign wb_ex_valid = retire & k_found & k_ex;
  assign wb_is_ertn  = retire & k_found & k_ertn & ~k_ex;
  assign wb_ex_pc    = k_pc;
  assign wb_ecode    = k_ecode;
  assign wb_esubcode = k_esub;
  assign wb_retire_cnt = retire_cnt;

  always_comb begin
    inc = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lv[i] && before_k[i]) inc = inc + CNT_W'(1);
    end
    if (wb_is_ertn) inc = inc + CNT_W'(1);
  end

  always_comb begin
    commit            = '0;
    fwd               = '0;
    wb_rf_zip         = '0;
    debug_wb_pc       = '0;
    debug_wb_rf_we    = '0;
    debug_wb_rf_wnum  = '0;
    debug_wb_rf_wdata = '0;
    for (int i = 0; i < LANES; i++) begin
      commit[i] = retire & lv[i] & we[i] & before_k[i];
      // forwarded data is final even while the bundle is stalled
      fwd[i]    = vld_p1 & run & lv[i] & we[i] & before_k[i];
      wb_rf_zip[i*RFW +: RFW]                 = {fwd[i], waddr[i], wdata[i]};
      debug_wb_pc[i*PC_W +: PC_W]             = pc[i];
      debug_wb_rf_we[i*4 +: 4]                = {4{commit[i]}};
      debug_wb_rf_wnum[i*RADDR_W +: RADDR_W]  = waddr[i];
      debug_wb_rf_wdata[i*DATA_W +: DATA_W]   = wdata[i];
    end
  end

  // stage p0 -> p1: bundle capture
  always_ff @(posedge clk) begin
    if (reset) begin
      zip_p1 <= '0;
    end else if (wb_allowin && mem_to_wb_valid) begin
      zip_p1 <= mem_to_wb_zip;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1     <= 1'b0;
      state      <= ST_RUN;
      kcnt       <= '0;
      retire_cnt <= '0;
    end else if (state == ST_KILL) begin
      if (kcnt == '0) begin
        state  <= ST_RUN;
        vld_p1 <= 1'b0;
      end else begin
        kcnt   <= kcnt - KCW'(1);
        vld_p1 <= mem_to_wb_valid;
      end
    end else begin
      if (wb_allowin) vld_p1 <= mem_to_wb_valid;
      if (retire) retire_cnt <= retire_cnt + inc;
      if (retire && k_found && (KILL_CYC > 0)) begin
        state <= ST_KILL;
        kcnt  <= KCW'(KILL_CYC - 1);
      end
    end
  end

endmodule

// File: tb/tb_wb_stage_multilane.sv
// Directed bench for wb_stage_multilane at default parameters (LANES=2, KILL_CYC=1).
module tb_wb_stage_multilane;

  logic         clk = 1'b0;
  logic         reset;
  logic         wb_allowin;
  logic         mem_to_wb_valid;
  logic [175:0] mem_to_wb_zip;
  logic         wb_stall;
  logic [75:0]  wb_rf_zip;
  logic [63:0]  debug_wb_pc;
  logic [7:0]   debug_wb_rf_we;
  logic [9:0]   debug_wb_rf_wnum;
  logic [63:0]  debug_wb_rf_wdata;
  logic         wb_ex_valid;
  logic [31:0]  wb_ex_pc;
  logic [5:0]   wb_ecode;
  logic [8:0]   wb_esubcode;
  logic         wb_is_ertn;
  logic [63:0]  wb_retire_cnt;

  int nchk = 0;
  int nerr = 0;

  wb_stage_multilane dut (
    .clk(clk), .reset(reset), .wb_allowin(wb_allowin),
    .mem_to_wb_valid(mem_to_wb_valid), .mem_to_wb_zip(mem_to_wb_zip),
    .wb_stall(wb_stall), .wb_rf_zip(wb_rf_zip), .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_we(debug_wb_rf_we), .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata), .wb_ex_valid(wb_ex_valid),
    .wb_ex_pc(wb_ex_pc), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
    .wb_is_ertn(wb_is_ertn), .wb_retire_cnt(wb_retire_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [87:0] pkt(input logic lv, input logic we, input logic [4:0] wa,
                                      input logic [31:0] wd, input logic [31:0] pc,
                                      input logic ex, input logic [5:0] ec,
                                      input logic [8:0] es, input logic ertn);
    return {lv, we, wa, wd, pc, ex, ec, es, ertn};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_to_wb_valid = 1'b0;
    mem_to_wb_zip   = '0;
    wb_stall        = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    step();
    step();
    reset = 1'b0;
    #1;
    nchk++; if (wb_allowin !== 1'b1) begin nerr++; $display("FAIL reset_allowin got=%0b exp=1", wb_allowin); end
    nchk++; if (debug_wb_rf_we !== 8'h00) begin nerr++; $display("FAIL reset_we got=%h exp=00", debug_wb_rf_we); end
    nchk++; if (wb_retire_cnt !== 64'd0) begin nerr++; $display("FAIL reset_cnt got=%0d exp=0", wb_retire_cnt); end
    nchk++; if ({wb_rf_zip, debug_wb_pc, debug_wb_rf_wnum, debug_wb_rf_wdata} !== '0) begin nerr++; $display("FAIL reset_data nonzero outputs"); end
    nchk++; if ({wb_ex_valid, wb_ex_pc, wb_ecode, wb_esubcode, wb_is_ertn} !== '0) begin nerr++; $display("FAIL reset_ex nonzero exception outputs"); end
  endtask

  task automatic test_two_writes();
    step();
    mem_to_wb_valid = 1'b1;
    mem_to_wb_zip = {pkt(1,1,5'd4,32'h22,32'h1C000004,0,0,0,0), pkt(1,1,5'd3,32'h11,32'h1C000000,0,0,0,0)};
    step();
    idle();
    #1;
    nchk++; if (debug_wb_rf_we !== 8'hFF) begin nerr++; $display("FAIL two_we got=%h exp=ff", debug_wb_rf_we); end
    nchk++; if (debug_wb_rf_wnum !== {5'd4, 5'd3}) begin nerr++; $display("FAIL two_wnum got=%h exp=%h", debug_wb_rf_wnum, {5'd4, 5'd3}); end
    nchk++; if (debug_wb_rf_wdata !== {32'h22, 32'h11}) begin nerr++; $display("FAIL two_wdata got=%h", debug_wb_rf_wdata); end
    nchk++; if (debug_wb_pc !== {32'h1C000004, 32'h1C000000}) begin nerr++; $display("FAIL two_pc got=%h", debug_wb_pc); end
    nchk++; if (wb_rf_zip !== {1'b1, 5'd4, 32'h22, 1'b1, 5'd3, 32'h11}) begin nerr++; $display("FAIL two_fwd got=%h", wb_rf_zip); end
    step();
    nchk++; if (wb_retire_cnt !== 64'd2) begin nerr++; $display("FAIL two_cnt got=%0d exp=2", wb_retire_cnt); end
    nchk++; if (debug_wb_rf_we !== 8'h00) begin nerr++; $display("FAIL two_idle_we got=%h exp=00", debug_wb_rf_we); end
  endtask

  task automatic test_exception();
    mem_to_wb_valid = 1'b1;
    mem_to_wb_zip = {pkt(1,1,5'd5,32'h55,32'h1C000104,0,0,0,0), pkt(1,0,5'd0,32'h0,32'h1C000100,1,6'h0B,9'h0,0)};
    step();
    mem_to_wb_zip = {pkt(0,0,5'd0,32'h0,32'h0,0,0,0,0), pkt(1,1,5'd7,32'h77,32'h1C000108,0,0,0,0)};
    #1;
    nchk++; if (wb_ex_valid !== 1'b1) begin nerr++; $display("FAIL ex_valid got=%0b exp=1", wb_ex_valid); end
    nchk++; if (wb_ex_pc !== 32'h1C000100) begin nerr++; $display("FAIL ex_pc got=%h exp=1c000100", wb_ex_pc); end
    nchk++; if (wb_ecode !== 6'h0B) begin nerr++; $display("FAIL ex_ecode got=%h exp=0b", wb_ecode); end
    nchk++; if (wb_is_ertn !== 1'b0) begin nerr++; $display("FAIL ex_ertn got=%0b exp=0", wb_is_ertn); end
    nchk++; if (debug_wb_rf_we !== 8'h00) begin nerr++; $display("FAIL ex_we got=%h exp=00", debug_wb_rf_we); end
    nchk++; if ({wb_rf_zip[75], wb_rf_zip[37]} !== 2'b00) begin nerr++; $display("FAIL ex_fwd got=%b exp=00", {wb_rf_zip[75], wb_rf_zip[37]}); end
    step();
    idle();
    #1;
    nchk++; if (wb_retire_cnt !== 64'd2) begin nerr++; $display("FAIL ex_cnt got=%0d exp=2", wb_retire_cnt); end
    nchk++; if (debug_wb_rf_we !== 8'h00) begin nerr++; $display("FAIL kill_we got=%h exp=00", debug_wb_rf_we); end
    nchk++; if (wb_rf_zip[37] !== 1'b0) begin nerr++; $display("FAIL kill_fwd got=%0b exp=0", wb_rf_zip[37]); end
    nchk++; if (wb_ex_valid !== 1'b0) begin nerr++; $display("FAIL kill_ex got=%0b exp=0", wb_ex_valid); end
    step();
    nchk++; if (debug_wb_rf_we !== 8'h00) begin nerr++; $display("FAIL post_kill_we got=%h exp=00", debug_wb_rf_we); end
    nchk++; if (wb_retire_cnt !== 64'd2) begin nerr++; $display("FAIL post_kill_cnt got=%0d exp=2", wb_retire_cnt); end
  endtask

  task automatic test_ertn();
    mem_to_wb_valid = 1'b1;
    mem_to_wb_zip = {pkt(1,0,5'd0,32'h0,32'h1C000204,0,0,0,1), pkt(1,1,5'd6,32'h33,32'h1C000200,0,0,0,0)};
    step();
    mem_to_wb_zip = {pkt(0,0,5'd0,32'h0,32'h0,0,0,0,0), pkt(1,1,5'd8,32'h88,32'h1C000208,0,0,0,0)};
    #1;
    nchk++; if (debug_wb_rf_we !== 8'h0F) begin nerr++; $display("FAIL ertn_we got=%h exp=0f", debug_wb_rf_we); end
    nchk++; if (wb_is_ertn !== 1'b1) begin nerr++; $display("FAIL ertn_flag got=%0b exp=1", wb_is_ertn); end
    nchk++; if (wb_ex_valid !== 1'b0) begin nerr++; $display("FAIL ertn_ex got=%0b exp=0", wb_ex_valid); end
    nchk++; if (wb_ex_pc !== 32'h1C000204) begin nerr++; $display("FAIL ertn_pc got=%h exp=1c000204", wb_ex_pc); end
    nchk++; if ({wb_rf_zip[75], wb_rf_zip[37]} !== 2'b01) begin nerr++; $display("FAIL ertn_fwd got=%b exp=01", {wb_rf_zip[75], wb_rf_zip[37]}); end
    step();
    mem_to_wb_valid = 1'b0;
    wb_stall = 1'b1;
    #1;
    nchk++; if (wb_retire_cnt !== 64'd4) begin nerr++; $display("FAIL ertn_cnt got=%0d exp=4", wb_retire_cnt); end
    nchk++; if (wb_allowin !== 1'b1) begin nerr++; $display("FAIL kill_allowin got=%0b exp=1", wb_allowin); end
    nchk++; if (debug_wb_rf_we !== 8'h00) begin nerr++; $display("FAIL ertn_kill_we got=%h exp=00", debug_wb_rf_we); end
    step();
    nchk++; if (wb_allowin !== 1'b1) begin nerr++; $display("FAIL run_cleared_allowin got=%0b exp=1", wb_allowin); end
    nchk++; if (wb_rf_zip[37] !== 1'b0) begin nerr++; $display("FAIL run_cleared_fwd got=%0b exp=0", wb_rf_zip[37]); end
    idle();
    step();
    nchk++; if (wb_retire_cnt !== 64'd4) begin nerr++; $display("FAIL ertn_post_cnt got=%0d exp=4", wb_retire_cnt); end
  endtask

  task automatic test_stall();
    mem_to_wb_valid = 1'b1;
    mem_to_wb_zip = {pkt(1,1,5'd10,32'hAA,32'h1C000304,0,0,0,0), pkt(1,1,5'd9,32'h99,32'h1C000300,0,0,0,0)};
    step();
    wb_stall = 1'b1;
    mem_to_wb_zip = {pkt(0,0,5'd0,32'h0,32'h0,0,0,0,0), pkt(1,1,5'd11,32'hBB,32'h1C000308,0,0,0,0)};
    for (int c = 0; c < 3; c++) begin
      #1;
      nchk++; if (wb_allowin !== 1'b0) begin nerr++; $display("FAIL stall_allowin cyc=%0d got=%0b exp=0", c, wb_allowin); end
      nchk++; if (debug_wb_rf_we !== 8'h00) begin nerr++; $display("FAIL stall_we cyc=%0d got=%h exp=00", c, debug_wb_rf_we); end
      nchk++; if ({wb_rf_zip[75], wb_rf_zip[37]} !== 2'b11) begin nerr++; $display("FAIL stall_fwd cyc=%0d got=%b exp=11", c, {wb_rf_zip[75], wb_rf_zip[37]}); end
      nchk++; if (debug_wb_rf_wnum !== {5'd10, 5'd9}) begin nerr++; $display("FAIL stall_hold cyc=%0d got=%h", c, debug_wb_rf_wnum); end
      nchk++; if (wb_retire_cnt !== 64'd4) begin nerr++; $display("FAIL stall_cnt cyc=%0d got=%0d exp=4", c, wb_retire_cnt); end
      step();
    end
    wb_stall = 1'b0;
    #1;
    nchk++; if (debug_wb_rf_we !== 8'hFF) begin nerr++; $display("FAIL release_we got=%h exp=ff", debug_wb_rf_we); end
    nchk++; if (wb_allowin !== 1'b1) begin nerr++; $display("FAIL release_allowin got=%0b exp=1", wb_allowin); end
    step();
    idle();
    #1;
    nchk++; if (wb_retire_cnt !== 64'd6) begin nerr++; $display("FAIL release_cnt got=%0d exp=6", wb_retire_cnt); end
    nchk++; if (debug_wb_rf_we !== 8'h0F) begin nerr++; $display("FAIL b2b_we got=%h exp=0f", debug_wb_rf_we); end
    nchk++; if (debug_wb_rf_wnum[4:0] !== 5'd11) begin nerr++; $display("FAIL b2b_wnum got=%0d exp=11", debug_wb_rf_wnum[4:0]); end
    step();
    nchk++; if (wb_retire_cnt !== 64'd7) begin nerr++; $display("FAIL b2b_cnt got=%0d exp=7", wb_retire_cnt); end
  endtask

  task automatic test_lane_valid();
    mem_to_wb_valid = 1'b1;
    mem_to_wb_zip = {pkt(0,1,5'd13,32'hDD,32'h1C000404,0,0,0,0), pkt(1,1,5'd12,32'hCC,32'h1C000400,0,0,0,0)};
    step();
    mem_to_wb_zip = {pkt(0,0,5'd0,32'h0,32'h1C000504,1,6'h3F,9'h1,0), pkt(1,1,5'd14,32'hEE,32'h1C000500,0,0,0,0)};
    #1;
    nchk++; if (debug_wb_rf_we !== 8'h0F) begin nerr++; $display("FAIL lv0_we got=%h exp=0f", debug_wb_rf_we); end
    nchk++; if (wb_rf_zip[75] !== 1'b0) begin nerr++; $display("FAIL lv0_fwd got=%0b exp=0", wb_rf_zip[75]); end
    step();
    mem_to_wb_zip = {pkt(0,0,5'd0,32'h0,32'h0,0,0,0,0), pkt(1,1,5'd15,32'hFF,32'h1C000600,0,0,0,0)};
    #1;
    nchk++; if (wb_retire_cnt !== 64'd8) begin nerr++; $display("FAIL lv0_cnt got=%0d exp=8", wb_retire_cnt); end
    nchk++; if (wb_ex_valid !== 1'b0) begin nerr++; $display("FAIL lv0_ex got=%0b exp=0", wb_ex_valid); end
    nchk++; if (wb_ecode !== 6'h00) begin nerr++; $display("FAIL lv0_ecode got=%h exp=00", wb_ecode); end
    nchk++; if (debug_wb_rf_we !== 8'h0F) begin nerr++; $display("FAIL lv0_ex_we got=%h exp=0f", debug_wb_rf_we); end
    step();
    idle();
    #1;
    nchk++; if (debug_wb_rf_we !== 8'h0F) begin nerr++; $display("FAIL nokill_we got=%h exp=0f", debug_wb_rf_we); end
    nchk++; if (debug_wb_rf_wnum[4:0] !== 5'd15) begin nerr++; $display("FAIL nokill_wnum got=%0d exp=15", debug_wb_rf_wnum[4:0]); end
    step();
    nchk++; if (wb_retire_cnt !== 64'd10) begin nerr++; $display("FAIL nokill_cnt got=%0d exp=10", wb_retire_cnt); end
  endtask

  task automatic test_reset_mid();
    mem_to_wb_valid = 1'b1;
    mem_to_wb_zip = {pkt(1,1,5'd2,32'h12,32'h1C000704,0,0,0,0), pkt(1,1,5'd1,32'h21,32'h1C000700,0,0,0,0)};
    step();
    wb_stall = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle();
    #1;
    nchk++; if (wb_allowin !== 1'b1) begin nerr++; $display("FAIL rst_stall_allowin got=%0b exp=1", wb_allowin); end
    nchk++; if (wb_retire_cnt !== 64'd0) begin nerr++; $display("FAIL rst_stall_cnt got=%0d exp=0", wb_retire_cnt); end
    nchk++; if ({wb_rf_zip, debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata} !== '0) begin nerr++; $display("FAIL rst_stall_data nonzero outputs"); end
    mem_to_wb_valid = 1'b1;
    mem_to_wb_zip = {pkt(0,0,5'd0,32'h0,32'h0,0,0,0,0), pkt(1,0,5'd0,32'h0,32'h1C000800,1,6'h08,9'h0,0)};
    step();
    mem_to_wb_zip = {pkt(0,0,5'd0,32'h0,32'h0,0,0,0,0), pkt(1,1,5'd3,32'h31,32'h1C000804,0,0,0,0)};
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle();
    #1;
    nchk++; if (wb_allowin !== 1'b1) begin nerr++; $display("FAIL rst_kill_allowin got=%0b exp=1", wb_allowin); end
    nchk++; if ({wb_rf_zip, debug_wb_pc, debug_wb_rf_we, wb_retire_cnt} !== '0) begin nerr++; $display("FAIL rst_kill_data nonzero outputs"); end
    nchk++; if ({wb_ex_valid, wb_ex_pc, wb_ecode, wb_esubcode, wb_is_ertn} !== '0) begin nerr++; $display("FAIL rst_kill_ex nonzero exception outputs"); end
    mem_to_wb_valid = 1'b1;
    mem_to_wb_zip = {pkt(0,0,5'd0,32'h0,32'h0,0,0,0,0), pkt(1,1,5'd4,32'h41,32'h1C000900,0,0,0,0)};
    step();
    idle();
    #1;
    nchk++; if (debug_wb_rf_we !== 8'h0F) begin nerr++; $display("FAIL rst_run_we got=%h exp=0f", debug_wb_rf_we); end
    step();
    nchk++; if (wb_retire_cnt !== 64'd1) begin nerr++; $display("FAIL rst_run_cnt got=%0d exp=1", wb_retire_cnt); end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_two_writes();
    test_exception();
    test_ertn();
    test_stall();
    test_lane_valid();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
